// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_pkg                                                |
// | Description : Shared op encodings, default latencies and helpers for |
// |               the multiply/divide unit. The MDU_MADD_EN macro adds   |
// |               MADD/MADDU to the set of operations that start the MDU.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mdu_pkg;

  // E-stage MDU operation codes; any code not listed behaves as OP_NONE.
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for operations that occupy the unit for a multi-cycle busy period.
  function automatic logic is_start_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Divides use the long latency; everything else that starts uses the short one.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_if                                                 |
// | Description : E-stage bus between the pipeline and the MDU: op and   |
// |               operands in, start/busy handshake and HI/LO reads out. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface mdu_if;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi_dbg;
  logic [31:0] lo_dbg;

  modport master (
    output op, a, b, req,
    input  start, busy, out, hi_dbg, lo_dbg
  );

  modport slave (
    input  op, a, b, req,
    output start, busy, out, hi_dbg, lo_dbg
  );
endinterface
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_arith                                              |
// | Description : Combinational 64-bit result generator for MULT/MULTU/  |
// |               DIV/DIVU (and MADD/MADDU when MDU_MADD_EN is defined). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mdu_arith
  import mdu_pkg::*;
(
  input  wire logic [3:0]  op_i,
  input  wire logic [31:0] a_i,
  input  wire logic [31:0] b_i,
  input  wire logic [63:0] hilo_i,
  output logic      [63:0] result_o,
  output logic             div_by_zero_o
);

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_b_zero;
  logic [31:0] w_b_safe;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;

  assign w_smul = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign w_umul = {32'd0, a_i} * {32'd0, b_i};

  // A zero divisor is replaced by 1 so the dividers never see x/0; the
  // result is discarded in that case anyway.
  assign w_b_zero = (b_i == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : b_i;
  assign w_uq     = a_i / w_b_safe;
  assign w_ur     = a_i % w_b_safe;

  // Signed divide on magnitudes: quotient negated when signs differ,
  // remainder takes the sign of the dividend. 0x80000000 / -1 falls out
  // naturally as quotient 0x80000000, remainder 0.
  assign w_a_neg  = a_i[31];
  assign w_b_neg  = b_i[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - a_i) : a_i;
  assign w_b_mag  = w_b_zero ? 32'd1 : (w_b_neg ? (32'd0 - b_i) : b_i);
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;
  assign w_sq     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
  assign w_sr     = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;

  // Select the 64-bit {HI,LO} result; non-arithmetic ops leave HI/LO as-is.
  always_comb begin
    result_o      = hilo_i;
    div_by_zero_o = 1'b0;
    case (op_i)
      OP_MULT:  result_o = w_smul;
      OP_MULTU: result_o = w_umul;
      OP_DIV: begin
        div_by_zero_o = w_b_zero;
        result_o      = w_b_zero ? hilo_i : {w_sr, w_sq};
      end
      OP_DIVU: begin
        div_by_zero_o = w_b_zero;
        result_o      = w_b_zero ? hilo_i : {w_ur, w_uq};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result_o = hilo_i + w_smul;
      OP_MADDU: result_o = hilo_i + w_umul;
`endif
      default:  result_o = hilo_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_core                                               |
// | Description : Multi-cycle multiply/divide unit with HI/LO registers, |
// |               start/busy handshake and MFHI/MFLO read port.          |
// |               MDU_MADD_EN enables MADD/MADDU accumulate ops.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mdu_core
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  wire logic clk,
  input  wire logic reset_n,
  mdu_if.slave      bus
);

  localparam logic [3:0] C_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_N  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        dz_q, dz_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic        w_start;
  logic [63:0] w_result;
  logic        w_div_by_zero;

  mdu_arith u_arith (
    .op_i          (bus.op),
    .a_i           (bus.a),
    .b_i           (bus.b),
    .hilo_i        ({hi_q, lo_q}),
    .result_o      (w_result),
    .div_by_zero_o (w_div_by_zero)
  );

  // A new operation may only launch when the unit is idle and no exception is taken.
  assign w_start = is_start_op(bus.op) && !bus.req && !busy_q;

  // Next-state: count down the busy window, commit on 1->0, else accept starts and moves.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    dz_d   = dz_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        if (!dz_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end
    end else if (w_start) begin
      pend_d = w_result;
      dz_d   = w_div_by_zero;
      cnt_d  = is_div_op(bus.op) ? C_DIV_N : C_MULT_N;
      busy_d = 1'b1;
    end else if (!bus.req) begin
      if (bus.op == OP_MTHI) hi_d = bus.a;
      if (bus.op == OP_MTLO) lo_d = bus.a;
    end
  end

  // State registers; reset aborts any in-flight operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      pend_q <= 64'd0;
      dz_q   <= 1'b0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
      dz_q   <= dz_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign bus.start  = w_start;
  assign bus.busy   = busy_q;
  assign bus.out    = (bus.op == OP_MFHI) ? hi_q :
                      (bus.op == OP_MFLO) ? lo_q : 32'd0;
  assign bus.hi_dbg = hi_q;
  assign bus.lo_dbg = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mdu_core                                            |
// | Description : Self-checking bench for mdu_core: directed cases plus  |
// |               random ops against a cycle-level reference model.      |
// |               Honours MDU_MADD_EN for MADD/MADDU expectations.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mdu_core;
  import mdu_pkg::*;

  localparam int C_MULT_N = 5;
  localparam int C_DIV_N  = 10;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  // Reference model state: architectural HI/LO, pending result, cycles left.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_left;

  mdu_if bus ();

  mdu_core #(
    .MULT_CYCLES (C_MULT_N),
    .DIV_CYCLES  (C_DIV_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_is_start(input logic [3:0] op);
    if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) return 1'b1;
`ifdef MDU_MADD_EN
    if (op == OP_MADD || op == OP_MADDU) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Architectural result of a start op using plain 64-bit arithmetic; x/0 keeps HI/LO.
  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hilo);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return hilo;
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 32'd0) return hilo;
        q = 32'(ua / ub);
        r = 32'(ua % ub);
        return {r, q};
      end
      OP_MADD:  return hilo + 64'(sa * sb);
      OP_MADDU: return hilo + ua * ub;
      default:  return hilo;
    endcase
  endfunction

  // One pipeline cycle: drive, check combinational outputs, clock, advance model, check state.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic r);
    logic        exp_start;
    logic [31:0] exp_out;
    @(negedge clk);
    bus.op  = op;
    bus.a   = a;
    bus.b   = b;
    bus.req = r;
    #1;
    exp_start = m_is_start(op) && !r && (m_left == 0);
    exp_out   = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
    check("start", {31'd0, bus.start}, {31'd0, exp_start});
    check("out", bus.out, exp_out);
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (exp_start) begin
      m_pend = ref_calc(op, a, b, {m_hi, m_lo});
      m_left = (op == OP_DIV || op == OP_DIVU) ? C_DIV_N : C_MULT_N;
    end else if (!r) begin
      if (op == OP_MTHI) m_hi = a;
      if (op == OP_MTLO) m_lo = a;
    end
    #1;
    check("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
    check("hi", bus.hi_dbg, m_hi);
    check("lo", bus.lo_dbg, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(OP_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rreq;
    tests   = 0;
    fails   = 0;
    m_hi    = '0;
    m_lo    = '0;
    m_pend  = '0;
    m_left  = 0;
    bus.op  = OP_NONE;
    bus.a   = '0;
    bus.b   = '0;
    bus.req = 1'b0;
    reset_n = 1'b0;

    // Reset state
    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_start", {31'd0, bus.start}, 32'd0);
    check("rst_hi", bus.hi_dbg, 32'd0);
    check("rst_lo", bus.lo_dbg, 32'd0);
    check("rst_out", bus.out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // MULT -2 * 3, then MFHI/MFLO once the result lands
    step(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(C_MULT_N);
    step(OP_MFHI, 32'd0, 32'd0, 1'b0);
    check("mult_hi", bus.hi_dbg, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo_dbg, 32'hFFFF_FFFA);
    step(OP_MFLO, 32'd0, 32'd0, 1'b0);

    // DIVU 100 / 7
    step(OP_DIVU, 32'd100, 32'd7, 1'b0);
    idle(C_DIV_N);
    check("divu_lo", bus.lo_dbg, 32'd14);
    check("divu_hi", bus.hi_dbg, 32'd2);

    // DIV -7 / 2, with MFHI during busy showing the old value
    step(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    step(OP_MFHI, 32'd0, 32'd0, 1'b0);
    idle(C_DIV_N - 1);
    check("div_lo", bus.lo_dbg, 32'hFFFF_FFFD);
    check("div_hi", bus.hi_dbg, 32'hFFFF_FFFF);

    // Divide by zero keeps preloaded HI/LO
    step(OP_MTHI, 32'h11, 32'd0, 1'b0);
    step(OP_MTLO, 32'h22, 32'd0, 1'b0);
    step(OP_DIV, 32'd5, 32'd0, 1'b0);
    idle(C_DIV_N);
    check("dz_hi", bus.hi_dbg, 32'h11);
    check("dz_lo", bus.lo_dbg, 32'h22);

    // Exception blocks start; the following MTLO proceeds
    step(OP_MULTU, 32'd5, 32'd6, 1'b1);
    step(OP_MTLO, 32'hABCD, 32'd0, 1'b0);
    check("mtlo", bus.lo_dbg, 32'hABCD);
    step(OP_MTHI, 32'h1234, 32'd0, 1'b1);

    // Overflow divide
    step(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(C_DIV_N);
    check("ovf_lo", bus.lo_dbg, 32'h8000_0000);
    check("ovf_hi", bus.hi_dbg, 32'd0);

    // Start/move while busy are ignored; req during busy does not cancel
    step(OP_MULTU, 32'd7, 32'd9, 1'b0);
    step(OP_DIV, 32'd50, 32'd3, 1'b0);
    step(OP_MTLO, 32'hDEAD, 32'd0, 1'b0);
    step(OP_NONE, 32'd0, 32'd0, 1'b1);
    idle(C_MULT_N - 3);
    check("req_busy_lo", bus.lo_dbg, 32'd63);

    // Accumulate (behaves as OP_NONE when the feature is absent)
    step(OP_MTHI, 32'd0, 32'd0, 1'b0);
    step(OP_MTLO, 32'd10, 32'd0, 1'b0);
    step(OP_MADD, 32'd2, 32'd3, 1'b0);
    idle(C_MULT_N);
    step(OP_MFLO, 32'd0, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    check("madd_lo", bus.lo_dbg, 32'd16);
`else
    check("madd_lo", bus.lo_dbg, 32'd10);
`endif
    step(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(C_MULT_N);

    // Random operations
    for (int i = 0; i < 400; i++) begin
      rop  = 4'($urandom_range(0, 15));
      ra   = $urandom;
      rb   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      rreq = ($urandom_range(0, 9) == 0);
      step(rop, ra, rb, rreq);
    end
    idle(C_DIV_N);

    // Reset in the middle of a divide aborts it
    step(OP_MTHI, 32'h55, 32'd0, 1'b0);
    step(OP_MTLO, 32'h66, 32'd0, 1'b0);
    step(OP_DIV, 32'd1000, 32'd9, 1'b0);
    idle(4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    m_hi   = '0;
    m_lo   = '0;
    m_left = 0;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_hi", bus.hi_dbg, 32'd0);
    check("arst_lo", bus.lo_dbg, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(C_DIV_N + 2);
    check("arst_nocommit_lo", bus.lo_dbg, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
